// File: rtl/mcb_port_emulator_pkg.sv
// ---------------------------------------------------------------------------
// mcb_port_emulator_pkg
// Shared definitions for the MCB user-port emulator: instruction codes,
// FSM state encoding, refresh duration and the packed command word layout.
// No ports (package).
// ---------------------------------------------------------------------------
package mcb_port_emulator_pkg;

    localparam logic [2:0] INSTR_WRITE    = 3'b000;
    localparam logic [2:0] INSTR_READ     = 3'b001;
    localparam logic [2:0] INSTR_WRITE_AP = 3'b010;
    localparam logic [2:0] INSTR_READ_AP  = 3'b011;
    localparam logic [2:0] INSTR_REFRESH  = 3'b100;

    localparam int REFRESH_CYCLES = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT    = 3'd1,
        ST_WRITE   = 3'd2,
        ST_READ    = 3'd3,
        ST_REFRESH = 3'd4
    } state_t;

    // 39-bit command FIFO entry
    typedef struct packed {
        logic [2:0]  instr;
        logic [5:0]  bl;
        logic [29:0] byte_addr;
    } cmd_t;

    // Auto-precharge variants map onto the plain operations; unknown
    // encodings map to IDLE so they are popped and dropped.
    function automatic state_t decode_instr(input logic [2:0] instr);
        state_t st;
        case (instr)
            INSTR_WRITE, INSTR_WRITE_AP: st = ST_WRITE;
            INSTR_READ,  INSTR_READ_AP:  st = ST_READ;
            INSTR_REFRESH:               st = ST_REFRESH;
            default:                     st = ST_IDLE;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/mcb_emu_fifo.sv
// ---------------------------------------------------------------------------
// mcb_emu_fifo
// Synchronous first-word-fall-through FIFO. Push while full and pop while
// empty are ignored; count/full/empty reflect the state after each edge.
// Ports:
//   clk, srst       clock, synchronous active-high reset
//   push, din       write side
//   pop, dout       read side (dout shows the head without a pop)
//   count           occupancy 0..DEPTH
//   full, empty     count==DEPTH / count==0
// ---------------------------------------------------------------------------
module mcb_emu_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     srst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = push && !w_full;
    assign w_pop   = pop && !w_empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign dout  = r_mem[r_rd_ptr];
    assign count = r_count;
    assign full  = w_full;
    assign empty = w_empty;

endmodule

// File: rtl/mcb_port_emulator.sv
// ---------------------------------------------------------------------------
// mcb_port_emulator
// Cycle-level stand-in for one LPDDR MCB user port backed by on-chip RAM
// (2**ADDR_W x 32 bit, byte-writable, registered read).
// Optional feature macro: MCB_EMU_LATENCY_EN -- inserts a WAIT state of
// READ_LAT cycles after every command pop.
// Ports:
//   clk, reset                           clock, synchronous active-high reset
//   cmd_en/instr/bl/byte_addr            command push; cmd_empty, cmd_full
//   wr_en/data/mask                      write-data push; wr_full/empty/count
//   wr_underrun, wr_error                burst stalled on empty write FIFO
//   rd_en, rd_data                       read FIFO pop / FWFT head
//   rd_full/empty/count                  read FIFO status
//   rd_overflow, rd_error                read word dropped on full FIFO
// ---------------------------------------------------------------------------
module mcb_port_emulator
    import mcb_port_emulator_pkg::*;
#(
    parameter int ADDR_W     = 10,
    parameter int CMD_DEPTH  = 4,
    parameter int DATA_DEPTH = 64,
    parameter int READ_LAT   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_en,
    input  logic [2:0]  cmd_instr,
    input  logic [5:0]  cmd_bl,
    input  logic [29:0] cmd_byte_addr,
    output logic        cmd_empty,
    output logic        cmd_full,
    input  logic        wr_en,
    input  logic [31:0] wr_data,
    input  logic [3:0]  wr_mask,
    output logic        wr_full,
    output logic        wr_empty,
    output logic [6:0]  wr_count,
    output logic        wr_underrun,
    output logic        wr_error,
    input  logic        rd_en,
    output logic [31:0] rd_data,
    output logic        rd_full,
    output logic        rd_empty,
    output logic [6:0]  rd_count,
    output logic        rd_overflow,
    output logic        rd_error
);
    // One down-counter serves refresh and (optionally) the WAIT latency
    localparam int LAT_W = $clog2(READ_LAT + 1);
    localparam int CNT_W = (LAT_W > 3) ? LAT_W : 3;

    cmd_t                          w_cmd_head;
    logic [$clog2(CMD_DEPTH):0]    w_cmd_count;
    logic                          w_cmd_empty;
    logic                          w_cmd_pop;
    logic [35:0]                   w_wr_head;
    logic [$clog2(DATA_DEPTH):0]   w_wr_count;
    logic                          w_wr_empty;
    logic                          w_wr_pop;
    logic [31:0]                   w_rd_head;
    logic [$clog2(DATA_DEPTH):0]   w_rd_count;
    logic                          w_rd_full;
    logic                          w_rd_empty;
    logic [31:0]                   w_ram_q;
    logic                          w_ram_we;
    logic                          w_rd_issue;
    logic                          w_wr_underrun;
    logic                          w_unused;

    state_t             r_state,  w_state_next;
    logic [ADDR_W-1:0]  r_addr,   w_addr_next;
    logic [5:0]         r_remaining, w_remaining_next;
    logic [CNT_W-1:0]   r_cnt,    w_cnt_next;
    logic               r_issue_done, w_issue_done_next;
    logic               r_rd_valid;
    logic               r_wr_error;
    logic               r_rd_error;
`ifdef MCB_EMU_LATENCY_EN
    state_t             r_target, w_target_next;
`endif

    mcb_emu_fifo #(.WIDTH(39), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .clk   (clk),
        .srst  (reset),
        .push  (cmd_en),
        .din   ({cmd_instr, cmd_bl, cmd_byte_addr}),
        .pop   (w_cmd_pop),
        .dout  (w_cmd_head),
        .count (w_cmd_count),
        .full  (cmd_full),
        .empty (w_cmd_empty)
    );

    mcb_emu_fifo #(.WIDTH(36), .DEPTH(DATA_DEPTH)) u_wr_fifo (
        .clk   (clk),
        .srst  (reset),
        .push  (wr_en),
        .din   ({wr_mask, wr_data}),
        .pop   (w_wr_pop),
        .dout  (w_wr_head),
        .count (w_wr_count),
        .full  (wr_full),
        .empty (w_wr_empty)
    );

    // Read data arrives one cycle after the RAM access was issued
    mcb_emu_fifo #(.WIDTH(32), .DEPTH(DATA_DEPTH)) u_rd_fifo (
        .clk   (clk),
        .srst  (reset),
        .push  (r_rd_valid),
        .din   (w_ram_q),
        .pop   (rd_en),
        .dout  (w_rd_head),
        .count (w_rd_count),
        .full  (w_rd_full),
        .empty (w_rd_empty)
    );

    // One RAM per byte lane so masked writes map onto plain block RAM
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] r_mem [2**ADDR_W];
            logic [7:0] r_q;
            always_ff @(posedge clk) begin
                if (w_ram_we && !w_wr_head[32+gi]) begin
                    r_mem[r_addr] <= w_wr_head[gi*8 +: 8];
                end
                r_q <= r_mem[r_addr];
            end
            assign w_ram_q[gi*8 +: 8] = r_q;
        end
    endgenerate

    always_comb begin
        w_state_next      = r_state;
        w_addr_next       = r_addr;
        w_remaining_next  = r_remaining;
        w_cnt_next        = r_cnt;
        w_issue_done_next = r_issue_done;
`ifdef MCB_EMU_LATENCY_EN
        w_target_next     = r_target;
`endif
        w_cmd_pop         = 1'b0;
        w_wr_pop          = 1'b0;
        w_rd_issue        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_cmd_empty) begin
                    w_cmd_pop         = 1'b1;
                    w_addr_next       = w_cmd_head.byte_addr[ADDR_W+1:2];
                    w_remaining_next  = w_cmd_head.bl;
                    w_issue_done_next = 1'b0;
`ifdef MCB_EMU_LATENCY_EN
                    if (decode_instr(w_cmd_head.instr) != ST_IDLE) begin
                        w_state_next  = ST_WAIT;
                        w_target_next = decode_instr(w_cmd_head.instr);
                        w_cnt_next    = CNT_W'(READ_LAT - 1);
                    end
`else
                    w_state_next = decode_instr(w_cmd_head.instr);
                    w_cnt_next   = CNT_W'(REFRESH_CYCLES - 1);
`endif
                end
            end
`ifdef MCB_EMU_LATENCY_EN
            ST_WAIT: begin
                if (r_cnt == '0) begin
                    w_state_next = r_target;
                    w_cnt_next   = CNT_W'(REFRESH_CYCLES - 1);
                end else begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end
            end
`endif
            ST_WRITE: begin
                if (!w_wr_empty) begin
                    w_wr_pop    = 1'b1;
                    w_addr_next = r_addr + ADDR_W'(1);
                    if (r_remaining == '0) begin
                        w_state_next = ST_IDLE;
                    end else begin
                        w_remaining_next = r_remaining - 6'd1;
                    end
                end
            end
            ST_READ: begin
                // Issue phase, then one extra cycle while the last word lands
                if (!r_issue_done) begin
                    w_rd_issue  = 1'b1;
                    w_addr_next = r_addr + ADDR_W'(1);
                    if (r_remaining == '0) begin
                        w_issue_done_next = 1'b1;
                    end else begin
                        w_remaining_next = r_remaining - 6'd1;
                    end
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_REFRESH: begin
                if (r_cnt == '0) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign w_ram_we      = w_wr_pop;
    assign w_wr_underrun = (r_state == ST_WRITE) && w_wr_empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_addr       <= '0;
            r_remaining  <= '0;
            r_cnt        <= '0;
            r_issue_done <= 1'b0;
            r_rd_valid   <= 1'b0;
            r_wr_error   <= 1'b0;
            r_rd_error   <= 1'b0;
`ifdef MCB_EMU_LATENCY_EN
            r_target     <= ST_IDLE;
`endif
        end else begin
            r_state      <= w_state_next;
            r_addr       <= w_addr_next;
            r_remaining  <= w_remaining_next;
            r_cnt        <= w_cnt_next;
            r_issue_done <= w_issue_done_next;
            r_rd_valid   <= w_rd_issue;
            r_wr_error   <= r_wr_error | w_wr_underrun;
            r_rd_error   <= r_rd_error | (r_rd_valid && w_rd_full);
`ifdef MCB_EMU_LATENCY_EN
            r_target     <= w_target_next;
`endif
        end
    end

    assign cmd_empty   = w_cmd_empty;
    assign wr_empty    = w_wr_empty;
    assign wr_count    = 7'(w_wr_count);
    assign wr_underrun = w_wr_underrun;
    assign wr_error    = r_wr_error;
    assign rd_data     = w_rd_empty ? 32'd0 : w_rd_head;
    assign rd_full     = w_rd_full;
    assign rd_empty    = w_rd_empty;
    assign rd_count    = 7'(w_rd_count);
    assign rd_overflow = r_rd_valid && w_rd_full;
    assign rd_error    = r_rd_error;

    // Address bits outside the RAM and the cmd occupancy are not needed
    assign w_unused = ^{w_cmd_head.byte_addr[29:ADDR_W+2],
                        w_cmd_head.byte_addr[1:0], w_cmd_count};

endmodule

// File: tb/tb_mcb_port_emulator.sv
// ---------------------------------------------------------------------------
// tb_mcb_port_emulator
// Directed bench for mcb_port_emulator. A word-level memory model plus an
// expected read-data queue predicts every popped read word; a negedge
// monitor compares each pop and tallies overflow/underrun pulses.
// ---------------------------------------------------------------------------
module tb_mcb_port_emulator;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_en = 1'b0;
    logic [2:0]  cmd_instr = '0;
    logic [5:0]  cmd_bl = '0;
    logic [29:0] cmd_byte_addr = '0;
    logic        cmd_empty, cmd_full;
    logic        wr_en = 1'b0;
    logic [31:0] wr_data = '0;
    logic [3:0]  wr_mask = '0;
    logic        wr_full, wr_empty, wr_underrun, wr_error;
    logic [6:0]  wr_count;
    logic        rd_en = 1'b0;
    logic [31:0] rd_data;
    logic        rd_full, rd_empty, rd_overflow, rd_error;
    logic [6:0]  rd_count;

    mcb_port_emulator dut (
        .clk(clk), .reset(reset),
        .cmd_en(cmd_en), .cmd_instr(cmd_instr), .cmd_bl(cmd_bl),
        .cmd_byte_addr(cmd_byte_addr), .cmd_empty(cmd_empty), .cmd_full(cmd_full),
        .wr_en(wr_en), .wr_data(wr_data), .wr_mask(wr_mask), .wr_full(wr_full),
        .wr_empty(wr_empty), .wr_count(wr_count), .wr_underrun(wr_underrun),
        .wr_error(wr_error), .rd_en(rd_en), .rd_data(rd_data), .rd_full(rd_full),
        .rd_empty(rd_empty), .rd_count(rd_count), .rd_overflow(rd_overflow),
        .rd_error(rd_error)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state
    logic [31:0] m_ram [0:1023];
    logic [35:0] pend[$];        // pushed write words not yet claimed by a cmd
    int          m_wr_addr = 0;
    int          m_wr_left = 0;
    logic [31:0] exp_q[$];       // read words expected to sit in the read FIFO
    int          exp_ovf = 0;
    logic [31:0] popped[$];
    int          ovf_cnt = 0;
    int          udr_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
            $display("check %s: got 0x%08h ok", name, act);
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic void model_apply();
        while (m_wr_left > 0 && pend.size() > 0) begin
            logic [35:0] w;
            w = pend.pop_front();
            for (int b = 0; b < 4; b++) begin
                if (!w[32+b]) m_ram[m_wr_addr][8*b +: 8] = w[8*b +: 8];
            end
            m_wr_addr = (m_wr_addr + 1) % 1024;
            m_wr_left--;
        end
    endfunction

    task automatic push_wr(input logic [31:0] d, input logic [3:0] m);
        wr_en = 1'b1; wr_data = d; wr_mask = m;
        @(posedge clk); #1;
        wr_en = 1'b0;
        pend.push_back({m, d});
        model_apply();
    endtask

    task automatic send_cmd(input logic [2:0] instr, input int bl, input int byte_addr);
        cmd_en = 1'b1; cmd_instr = instr; cmd_bl = 6'(bl); cmd_byte_addr = 30'(byte_addr);
        @(posedge clk); #1;
        cmd_en = 1'b0;
        if (instr == 3'b000 || instr == 3'b010) begin
            m_wr_addr = (byte_addr / 4) % 1024;
            m_wr_left = bl + 1;
            model_apply();
        end else if (instr == 3'b001 || instr == 3'b011) begin
            for (int i = 0; i <= bl; i++) begin
                if (exp_q.size() < 64) exp_q.push_back(m_ram[(byte_addr / 4 + i) % 1024]);
                else exp_ovf++;
            end
        end
    endtask

    task automatic wait_rd_count(input int n, input int limit, input string name);
        int k;
        k = 0;
        while (int'(rd_count) != n && k < limit) begin
            tick(1);
            k++;
        end
        if (k >= limit) check({name, "_timeout"}, 32'(rd_count), 32'(n));
    endtask

    task automatic wait_wr_empty(input int limit, input string name);
        int k;
        k = 0;
        while (!wr_empty && k < limit) begin
            tick(1);
            k++;
        end
        if (k >= limit) check({name, "_timeout"}, 32'(wr_count), 32'd0);
    endtask

    task automatic drain(input int n);
        popped.delete();
        rd_en = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        rd_en = 1'b0;
    endtask

    // Compare process: every popped word against the model queue
    always @(negedge clk) begin
        if (!reset) begin
            if (rd_overflow) ovf_cnt++;
            if (wr_underrun) udr_cnt++;
            if (rd_en && !rd_empty) begin
                popped.push_back(rd_data);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL rd_unexpected: got 0x%08h expected no word", rd_data);
                end else begin
                    check("rd_data", rd_data, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        tick(3);
        reset = 1'b0;
        tick(1);
        // Reset state
        check("rst_cmd_empty", 32'(cmd_empty), 32'd1);
        check("rst_wr_empty",  32'(wr_empty),  32'd1);
        check("rst_rd_empty",  32'(rd_empty),  32'd1);
        check("rst_flags", {24'd0, cmd_full, wr_full, rd_full, wr_underrun,
                            wr_error, rd_overflow, rd_error, 1'b0}, 32'd0);
        check("rst_counts", {18'd0, wr_count, rd_count}, 32'd0);
        check("rst_rd_data", rd_data, 32'd0);

        // Write 1..4 at 0x10, read back
        for (int i = 1; i <= 4; i++) push_wr(32'(i), 4'b0000);
        send_cmd(3'b000, 3, 'h10);
        wait_wr_empty(100, "wr1");
        tick(3);
        send_cmd(3'b001, 3, 'h10);
        wait_rd_count(4, 50, "rd1");
        tick(2);
        check("rd1_count", 32'(rd_count), 32'd4);
        drain(4);
        for (int i = 0; i < 4; i++) check("rd1_literal", popped[i], 32'(i + 1));

        // Byte mask merge (auto-precharge variants)
        push_wr(32'h11223344, 4'b0000);
        push_wr(32'hAABBCCDD, 4'b0101);
        send_cmd(3'b010, 0, 'h40);
        send_cmd(3'b000, 0, 'h40);
        wait_wr_empty(100, "mask");
        tick(3);
        send_cmd(3'b011, 0, 'h40);
        wait_rd_count(1, 50, "mask");
        drain(1);
        check("mask_literal", popped[0], 32'hAA22CC44);
        check("no_wr_error", 32'(wr_error), 32'd0);

        // Underrun: bl=1 with one word queued
        udr_cnt = 0;
        push_wr(32'h55, 4'b0000);
        send_cmd(3'b000, 1, 'h80);
        tick(10);
        check("udr_error", 32'(wr_error), 32'd1);
        check("udr_pulsed", 32'(udr_cnt > 0), 32'd1);
        push_wr(32'h66, 4'b0000);
        tick(5);
        udr_cnt = 0;
        tick(5);
        check("udr_stopped", 32'(udr_cnt), 32'd0);
        send_cmd(3'b001, 1, 'h80);
        wait_rd_count(2, 50, "udr");
        drain(2);
        check("udr_w0", popped[0], 32'h55);
        check("udr_w1", popped[1], 32'h66);

        // Fill words 0..63, check write FIFO full boundary
        for (int i = 0; i < 64; i++) push_wr(32'hC0DE0000 + 32'(i * 3), 4'b0000);
        check("wr_count_64", 32'(wr_count), 32'd64);
        check("wr_full", 32'(wr_full), 32'd1);
        send_cmd(3'b000, 63, 0);
        wait_wr_empty(200, "fill");
        tick(3);

        // Overflow: two 64-word reads with no pops
        ovf_cnt = 0;
        exp_ovf = 0;
        send_cmd(3'b001, 63, 0);
        send_cmd(3'b001, 63, 0);
        wait_rd_count(64, 300, "ovf");
        tick(80);
        check("ovf_count", 32'(rd_count), 32'd64);
        check("ovf_full", 32'(rd_full), 32'd1);
        check("ovf_pulses_model", 32'(ovf_cnt), 32'(exp_ovf));
        check("ovf_pulses", 32'(ovf_cnt), 32'd64);
        check("ovf_error", 32'(rd_error), 32'd1);
        drain(64);
        check("ovf_first", popped[0], 32'hC0DE0000);
        check("ovf_last", popped[63], 32'hC0DE0000 + 32'd189);

        // Address wrap, with refresh and an unused encoding in front
        push_wr(32'hA0A0A0A0, 4'b0000);
        push_wr(32'hB0B0B0B0, 4'b0000);
        send_cmd(3'b000, 1, 4 * 1023);
        wait_wr_empty(100, "wrap");
        tick(3);
        send_cmd(3'b100, 0, 0);
        send_cmd(3'b111, 5, 0);
        send_cmd(3'b001, 1, 4 * 1023);
        wait_rd_count(2, 50, "wrap");
        drain(2);
        check("wrap_last", popped[0], 32'hA0A0A0A0);
        check("wrap_zero", popped[1], 32'hB0B0B0B0);

        // Reset mid-read burst
        send_cmd(3'b001, 63, 0);
        tick(10);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        exp_q.delete();
        check("mid_rd_empty", 32'(rd_empty), 32'd1);
        check("mid_rd_count", 32'(rd_count), 32'd0);
        check("mid_cmd_empty", 32'(cmd_empty), 32'd1);
        check("mid_errors", {30'd0, wr_error, rd_error}, 32'd0);
        tick(3);
        check("mid_rd_count_held", 32'(rd_count), 32'd0);
        send_cmd(3'b001, 0, 0);
        wait_rd_count(1, 50, "post_rst");
        drain(1);
        check("post_rst_word", popped[0], 32'hB0B0B0B0);
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
